// File: rtl/apb_coeff_regfile.sv
// APB3 configuration slave for the DFE filter array: shadow/active coefficient banks
// with frame-aligned or immediate commit, direct control registers and W1C status.
module apb_coeff_regfile #(
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72,
  parameter int NUM_DENUM   = 5,
  parameter int N_FILT      = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic [PDATA_WIDTH-1:0]       PWDATA,
  output logic [PDATA_WIDTH-1:0]       PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic                         frame_strobe,
  input  logic [N_FILT-1:0]            ovf_in,
  input  logic [N_FILT-1:0]            udf_in,
  output logic [N_TAP*COEFF_WIDTH-1:0] FRAC_DECI_OUT,
  output logic                         FRAC_DECI_VLD,
  output logic [NUM_DENUM*COEFF_WIDTH-1:0] IIR_OUT,
  output logic                         IIR_VLD,
  output logic [4:0]                   CIC_R_OUT,
  output logic                         CIC_R_VLD,
  output logic [N_FILT-1:0]            CTRL_OUT,
  output logic [1:0]                   OUT_SEL
);

  localparam int TAP_IW = (N_TAP > 1) ? $clog2(N_TAP) : 1;
  localparam int IIR_IW = (NUM_DENUM > 1) ? $clog2(NUM_DENUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] A_IIR    = ADDR_WIDTH'(N_TAP);
  localparam logic [ADDR_WIDTH-1:0] A_CIC    = ADDR_WIDTH'(N_TAP + NUM_DENUM);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(N_TAP + NUM_DENUM + 1);
  localparam logic [ADDR_WIDTH-1:0] A_OUTSEL = ADDR_WIDTH'(N_TAP + NUM_DENUM + 2);
  localparam logic [ADDR_WIDTH-1:0] A_COMMIT = ADDR_WIDTH'(N_TAP + NUM_DENUM + 3);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(N_TAP + NUM_DENUM + 4);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                   state_reg;
  logic [1:0]               wait_cnt_reg;
  logic                     pready_reg;
  logic                     pslverr_reg;
  logic [PDATA_WIDTH-1:0]   prdata_reg;

  logic [COEFF_WIDTH-1:0]   frac_shadow_reg [N_TAP];
  logic [COEFF_WIDTH-1:0]   frac_active_reg [N_TAP];
  logic [COEFF_WIDTH-1:0]   iir_shadow_reg  [NUM_DENUM];
  logic [COEFF_WIDTH-1:0]   iir_active_reg  [NUM_DENUM];
  logic [4:0]               cic_shadow_reg;
  logic [4:0]               cic_active_reg;
  logic [N_FILT-1:0]        ctrl_reg;
  logic [1:0]               out_sel_reg;
  logic                     pending_reg;
  logic [2*N_FILT-1:0]      status_reg;
  logic                     vld_reg;

  logic                     mapped;
  logic                     finish;
  logic                     wr_en;
  logic                     commit_now;
  logic                     commit_frame;
  logic                     copy;
  logic [2*N_FILT-1:0]      status_clr;
  logic [PDATA_WIDTH-1:0]   rdata;
  logic                     unused_pwdata;

  function automatic logic [PDATA_WIDTH-1:0] sext(input logic [COEFF_WIDTH-1:0] c);
    return {{(PDATA_WIDTH-COEFF_WIDTH){c[COEFF_WIDTH-1]}}, c};
  endfunction

  assign mapped = (PADDR <= A_STATUS);
  // finish marks the edge after which PREADY is high for one cycle
  assign finish = PSEL && (
      (state_reg == S_SETUP && PENABLE && WAIT_STATES == 0) ||
      (state_reg == S_ACCESS && !pready_reg && wait_cnt_reg == 2'd1));
  assign wr_en        = (state_reg == S_ACCESS) && pready_reg && PSEL && PWRITE && mapped;
  assign commit_now   = wr_en && (PADDR == A_COMMIT) && PWDATA[1];
  assign commit_frame = wr_en && (PADDR == A_COMMIT) && PWDATA[0];
  assign copy         = commit_now || (pending_reg && frame_strobe);
  assign status_clr   = (wr_en && PADDR == A_STATUS) ? PWDATA[2*N_FILT-1:0] : '0;
  assign unused_pwdata = ^PWDATA[PDATA_WIDTH-1:COEFF_WIDTH];

  always_comb begin
    rdata = '0;
    if (PADDR < A_IIR) begin
      rdata = sext(frac_shadow_reg[PADDR[TAP_IW-1:0]]);
    end else if (PADDR < A_CIC) begin
      rdata = sext(iir_shadow_reg[IIR_IW'(PADDR - A_IIR)]);
    end else begin
      case (PADDR)
        A_CIC:    rdata[4:0]          = cic_shadow_reg;
        A_CTRL:   rdata[N_FILT-1:0]   = ctrl_reg;
        A_OUTSEL: rdata[1:0]          = out_sel_reg;
        A_COMMIT: rdata[0]            = pending_reg;
        A_STATUS: rdata[2*N_FILT-1:0] = status_reg;
        default:  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 2'd0;
      pready_reg   <= 1'b0;
      pslverr_reg  <= 1'b0;
      prdata_reg   <= '0;
    end else begin
      pready_reg  <= finish;
      pslverr_reg <= finish && !mapped;
      prdata_reg  <= (finish && !PWRITE && mapped) ? rdata : '0;
      case (state_reg)
        S_IDLE: begin
          if (PSEL && !PENABLE) state_reg <= S_SETUP;
        end
        S_SETUP: begin
          if (!PSEL) begin
            state_reg <= S_IDLE;
          end else if (PENABLE) begin
            state_reg    <= S_ACCESS;
            wait_cnt_reg <= 2'(WAIT_STATES);
          end
        end
        S_ACCESS: begin
          if (pready_reg) begin
            state_reg <= (PSEL && !PENABLE) ? S_SETUP : S_IDLE;
          end else if (!PSEL) begin
            state_reg <= S_IDLE;
          end else if (wait_cnt_reg != 2'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Copy samples the shadow value before any same-cycle write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAP; i++) begin
        frac_shadow_reg[i] <= '0;
        frac_active_reg[i] <= '0;
      end
      for (int i = 0; i < NUM_DENUM; i++) begin
        iir_shadow_reg[i] <= '0;
        iir_active_reg[i] <= '0;
      end
      cic_shadow_reg <= '0;
      cic_active_reg <= '0;
    end else begin
      for (int i = 0; i < N_TAP; i++) begin
        if (copy) frac_active_reg[i] <= frac_shadow_reg[i];
        if (wr_en && PADDR == ADDR_WIDTH'(i)) frac_shadow_reg[i] <= PWDATA[COEFF_WIDTH-1:0];
      end
      for (int i = 0; i < NUM_DENUM; i++) begin
        if (copy) iir_active_reg[i] <= iir_shadow_reg[i];
        if (wr_en && PADDR == A_IIR + ADDR_WIDTH'(i)) iir_shadow_reg[i] <= PWDATA[COEFF_WIDTH-1:0];
      end
      if (copy) cic_active_reg <= cic_shadow_reg;
      if (wr_en && PADDR == A_CIC) cic_shadow_reg <= PWDATA[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg    <= '0;
      out_sel_reg <= '0;
      pending_reg <= 1'b0;
      status_reg  <= '0;
      vld_reg     <= 1'b0;
    end else begin
      vld_reg <= copy;
      if (wr_en && PADDR == A_CTRL)   ctrl_reg    <= PWDATA[N_FILT-1:0];
      if (wr_en && PADDR == A_OUTSEL) out_sel_reg <= PWDATA[1:0];
      if (commit_now)        pending_reg <= 1'b0;
      else if (commit_frame) pending_reg <= 1'b1;
      else if (copy)         pending_reg <= 1'b0;
      // a new event outranks a simultaneous clear
      status_reg <= (status_reg & ~status_clr) | {udf_in, ovf_in};
    end
  end

  for (genvar gi = 0; gi < N_TAP; gi++) begin : g_frac_out
    assign FRAC_DECI_OUT[gi*COEFF_WIDTH +: COEFF_WIDTH] = frac_active_reg[gi];
  end
  for (genvar gi = 0; gi < NUM_DENUM; gi++) begin : g_iir_out
    assign IIR_OUT[gi*COEFF_WIDTH +: COEFF_WIDTH] = iir_active_reg[gi];
  end

  assign PRDATA        = prdata_reg;
  assign PREADY        = pready_reg;
  assign PSLVERR       = pslverr_reg;
  assign FRAC_DECI_VLD = vld_reg;
  assign IIR_VLD       = vld_reg;
  assign CIC_R_VLD     = vld_reg;
  assign CIC_R_OUT     = cic_active_reg;
  assign CTRL_OUT      = ctrl_reg;
  assign OUT_SEL       = out_sel_reg;

endmodule
